// File: rtl/ff_bank_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register bank between NREQ requesters.
// Each grant allows up to BURST load/toggle operations, followed by a one-cycle idle bubble.
module ff_bank_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          mode,
    input  logic [NREQ*WIDTH-1:0]    wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic                     busy,
    output logic [WIDTH-1:0]         q,
    output logic [WIDTH-1:0]         qn
);

    localparam int unsigned OW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(BURST + 1);

    typedef enum logic {StIdle, StOwn} state_e;

    state_e          state_q;
    logic [OW-1:0]   ptr_q;
    logic [CW-1:0]   cnt_q;

    logic            found;
    logic [OW-1:0]   pick;
    logic [OW-1:0]   cand;
    logic [OW-1:0]   ptr_next;
    logic            own_req;
    logic            own_mode;
    logic [WIDTH-1:0] own_data;
    logic            last_op;

    // Scan from the highest offset down so the lowest offset past ptr wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = OW'((int'(ptr_q) + i) % NREQ);
            if (req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        own_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (owner == OW'(k)) begin
                own_data = wdata[k*WIDTH +: WIDTH];
            end
        end
    end

    assign own_req  = req[owner];
    assign own_mode = mode[owner];
    assign last_op  = (cnt_q == CW'(BURST - 1));
    assign ptr_next = (owner == OW'(NREQ - 1)) ? '0 : owner + 1'b1;
    assign qn       = ~q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt     <= '0;
            busy    <= 1'b0;
            owner   <= '0;
            q       <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (found) begin
                        owner   <= pick;
                        gnt     <= NREQ'(1) << pick;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StOwn;
                    end
                end
                StOwn: begin
                    if (own_req) begin
                        q     <= own_mode ? (q ^ own_data) : own_data;
                        cnt_q <= cnt_q + 1'b1;
                    end
                    // Release on a dropped request or on the BURST-th operation.
                    if (!own_req || last_op) begin
                        gnt     <= '0;
                        busy    <= 1'b0;
                        ptr_q   <= ptr_next;
                        state_q <= StIdle;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ff_bank_arbiter.sv
// Bench for ff_bank_arbiter: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model of the arbitration rules.
module tb_ff_bank_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned BURST = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       mode;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [1:0]            owner;
    logic                  busy;
    logic [WIDTH-1:0]      q;
    logic [WIDTH-1:0]      qn;

    int errors = 0;
    int checks = 0;
    bit en = 1'b0;

    bit               m_busy = 1'b0;
    int               m_owner = 0;
    int               m_ptr = 0;
    int               m_cnt = 0;
    logic [WIDTH-1:0] m_q = '0;

    ff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .mode  (mode),
        .wdata (wdata),
        .gnt   (gnt),
        .owner (owner),
        .busy  (busy),
        .q     (q),
        .qn    (qn)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference model: one grant at a time, ops counted per grant, one idle cycle between grants.
    always @(posedge clk) begin
        bit               nb;
        bit               hit;
        int               no;
        int               np;
        int               nc;
        int               k;
        logic [WIDTH-1:0] nq;
        logic [WIDTH-1:0] d;
        nb = m_busy; no = m_owner; np = m_ptr; nc = m_cnt; nq = m_q;
        if (rst) begin
            nb = 1'b0; no = 0; np = 0; nc = 0; nq = '0;
        end else if (!m_busy) begin
            hit = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                k = (m_ptr + i) % NREQ;
                if (!hit && req[k]) begin
                    hit = 1'b1; nb = 1'b1; no = k; nc = 0;
                end
            end
        end else if (!req[m_owner]) begin
            nb = 1'b0;
            np = (m_owner + 1) % NREQ;
        end else begin
            d  = wdata[m_owner*WIDTH +: WIDTH];
            nq = mode[m_owner] ? (m_q ^ d) : d;
            nc = m_cnt + 1;
            if (nc == BURST) begin
                nb = 1'b0;
                np = (m_owner + 1) % NREQ;
            end
        end
        m_busy  <= nb;
        m_owner <= no;
        m_ptr   <= np;
        m_cnt   <= nc;
        m_q     <= nq;
    end

    always @(negedge clk) begin
        if (en) begin
            check("gnt", 32'(gnt), m_busy ? (32'd1 << m_owner) : 32'd0);
            check("busy", 32'(busy), 32'(m_busy));
            check("q", 32'(q), 32'(m_q));
            check("qn", 32'(qn), 32'(WIDTH'(~m_q)));
            check("onehot", 32'($countones(gnt) <= 1), 32'd1);
            if (m_busy) check("owner", 32'(owner), 32'(m_owner));
        end
    end

    initial begin
        rst = 1'b1; req = NREQ'($urandom); mode = '0; wdata = '0;
        tick(); tick();
        en = 1'b1;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_q", 32'(q), 32'h00);
        check("rst_qn", 32'(qn), 32'hFF);

        // Single load by requester 1.
        rst = 1'b0; req = 4'b0010; wdata[15:8] = 8'hA5;
        tick(); check("load_grant", 32'(gnt), 32'b0010);
        tick(); check("load_q", 32'(q), 32'hA5); check("load_qn", 32'(qn), 32'h5A);
        check("load_gnt_held", 32'(gnt), 32'b0010);
        req = '0;
        tick(); check("load_release", 32'(gnt), 32'h0);

        // Preload 0F through requester 2, then toggle with FF.
        req = 4'b0100; wdata[23:16] = 8'h0F;
        tick(); check("pre_grant", 32'(gnt), 32'b0100);
        tick(); check("pre_q", 32'(q), 32'h0F);
        req = '0;
        tick();
        mode = 4'b0100; wdata[23:16] = 8'hFF; req = 4'b0100;
        tick(); check("tog_grant", 32'(gnt), 32'b0100);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("tog_q", 32'(q), (i % 2 == 0) ? 32'hF0 : 32'h0F);
            check("tog_gnt", 32'(gnt), (i < 3) ? 32'b0100 : 32'h0);
        end
        tick(); check("tog_regrant", 32'(gnt), 32'b0100);
        req = '0;
        tick(); check("tog_drop_gnt", 32'(gnt), 32'h0); check("tog_drop_q", 32'(q), 32'h0F);

        // ptr is now 3; requesters 0 and 2 ask, so 0 wins by wrap, then 2.
        mode = '0; wdata[7:0] = 8'h3C; wdata[23:16] = 8'hC3; req = 4'b0101;
        tick(); check("wrap_grant0", 32'(gnt), 32'b0001);
        for (int i = 0; i < 4; i++) tick();
        check("wrap_release", 32'(gnt), 32'h0); check("wrap_q0", 32'(q), 32'h3C);
        tick(); check("wrap_grant2", 32'(gnt), 32'b0100);
        tick(); check("wrap_q2", 32'(q), 32'hC3);
        req = '0;
        tick(); check("wrap_drop", 32'(gnt), 32'h0);

        // All requesting from reset: 4 on / 1 off, owners 0,1,2,3,0.
        rst = 1'b1; req = 4'b1111; wdata = 32'h44332211;
        tick();
        rst = 1'b0;
        for (int e = 0; e < 25; e++) begin
            tick();
            check("rr_gnt", 32'(gnt), (e % 5 < 4) ? (32'd1 << ((e / 5) % 4)) : 32'd0);
        end
        tick(); tick(); tick();
        check("mid_q", 32'(q), 32'h22);
        rst = 1'b1;
        tick();
        check("abort_q", 32'(q), 32'h00); check("abort_gnt", 32'(gnt), 32'h0);
        check("abort_busy", 32'(busy), 32'h0); check("abort_qn", 32'(qn), 32'hFF);

        for (int n = 0; n < 1000; n++) begin
            rst   = ($urandom_range(0, 49) == 0);
            req   = NREQ'($urandom | $urandom);
            mode  = NREQ'($urandom);
            wdata = $urandom;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
